fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction fetch stage that sits directly upstream of the multi-cycle processor core's decode/execute state machine.
- Owns the fetch PC and issues reads to a single-port 16-bit instruction memory with 1-cycle read latency.
- Buffers returned words in a small FIFO and hands the core complete instructions over a valid/ready handshake. Call, jump and jumpf (opcodes 4'hC, 4'hD, 4'hE) are delivered bundled with their following target word.
- The core redirects fetch on taken jump/call/ret.

Parameters:
- DEPTH, 4: FIFO capacity in 16-bit words; power of two, minimum 2.
- RESET_PC, 16'h0000: fetch PC loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  read request this cycle.
- mem_addr  out  16  read address; valid when mem_req=1.
- mem_rdata  in  16  read data; valid the cycle after mem_req=1.
- redirect  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  16  new fetch address.
- stall_fetch  in  1  suppress new requests (core halted); in-flight data is still captured.
- out_valid  out  1  head instruction complete.
- out_ready  in  1  core accepts the head instruction.
- out_ir  out  16  instruction word.
- out_imm  out  16  following word for opcodes C/D/E; 0 otherwise.
- out_pc  out  16  address of out_ir.
- out_len2  out  1  instruction is two words (opcode C/D/E).

Behaviour:
- Reset: fetch_pc<=RESET_PC; FIFO empty; pending/kill flags cleared. Outputs mem_req=0, mem_addr=RESET_PC, out_valid=0, out_ir=0, out_imm=0, out_pc=0, out_len2=0. Reset mid-operation discards FIFO contents and any in-flight read.
- FIFO entries are {word, addr}. Occupancy counter 0..DEPTH. Head/tail pointers wrap modulo DEPTH.
- Request rule: mem_req=1 iff !reset && !redirect && !stall_fetch && (occupancy + pending) < DEPTH.
  - mem_addr=fetch_pc.
  - On mem_req, fetch_pc<=fetch_pc+1, wrapping 16'hFFFF->16'h0000; pending<=1.
- Response: in the cycle after mem_req, mem_rdata with its issue address is pushed at tail, unless kill is set.
- Output: out_* are driven combinationally from the FIFO head.
  - out_len2 = head opcode is C, D or E.
  - out_valid = occupancy>=1 for 1-word instructions, occupancy>=2 for 2-word instructions.
  - out_imm = word at head+1 when out_len2, else 0.
- Pop: on out_valid && out_ready, pop 1 or 2 entries per out_len2. Push and pop in the same cycle are both honoured. A full FIFO never drops a word, guaranteed by the pending accounting.
- Redirect (highest priority):
  - FIFO emptied; fetch_pc<=redirect_pc; mem_req=0 in the redirect cycle.
  - If a read was issued in the previous cycle, kill is set and that response is discarded.
  - A handshake coinciding with redirect completes: the core owns that instruction, then the flush applies.
  - Repeated redirects on consecutive cycles take the last redirect_pc.
- Redirect latency: redirect at T -> mem_req for redirect_pc at T+1 -> word written at end of T+2.
  - out_valid for a 1-word instruction at T+3.
  - out_valid for a 2-word instruction at T+4.
- Steady-state throughput: one word per cycle when the core accepts every cycle.
- stall_fetch: no new requests; the FIFO keeps draining normally; deasserting resumes fetching at the held fetch_pc.
- Trap (opcode 0, secondary 0) gets no special handling; the core asserts stall_fetch.

Test Plan:
- Reset, mem holds 16'h1123 at 0, out_ready=1 -> mem_req at addr 0,1,2,…; first out_valid with out_ir=16'h1123, out_pc=0, out_len2=0; then one instruction per cycle.
- mem[4]=16'hD000, mem[5]=16'h0040 -> single transfer: out_ir=16'hD000, out_imm=16'h0040, out_pc=4, out_len2=1; next head out_pc=6.
- out_ready=0 for 20 cycles -> occupancy saturates at DEPTH=4; no mem_req while full; words 0..3 delivered in order after release, no loss or duplication.
- Redirect to 16'h0100 while reads are in flight and the FIFO is non-empty -> stale response is discarded; next delivered out_pc=16'h0100 at T+3; no pre-redirect instruction appears after T.
- RESET_PC=16'hFFFF with a 2-word instruction at FFFF -> out_imm taken from address 0000; fetch_pc wraps to 0001.
- stall_fetch held with 3 words queued -> those 3 drain, then out_valid=0 and mem_req=0; assert reset mid-burst -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, reads a 1-cycle-latency instruction
// memory, buffers {word, addr} pairs and hands complete 1- or 2-word instructions to the core.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall_fetch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_ir,
    output logic [15:0] out_imm,
    output logic [15:0] out_pc,
    output logic        out_len2
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   word_q [DEPTH];
    logic [15:0]   addr_q [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;
    logic [15:0]   fetch_pc;
    logic [15:0]   pend_addr;
    logic          pending;

    logic          has1;
    logic          has2;
    logic          is_len2;
    logic [3:0]    head_op;
    logic [AW-1:0] head_plus1;
    logic          push;
    logic          pop;
    logic [CW-1:0] pop_cnt;
    logic [CW-1:0] occ_plus_pending;

    always_comb begin
        head_plus1       = head + AW'(1);
        head_op          = word_q[head][15:12];
        has1             = (count != '0);
        has2             = (count >= CW'(2));
        is_len2          = has1 && (head_op == 4'hC || head_op == 4'hD || head_op == 4'hE);
        occ_plus_pending = count + CW'(pending);

        out_len2  = is_len2;
        out_valid = is_len2 ? has2 : has1;
        out_ir    = has1 ? word_q[head] : 16'h0000;
        out_pc    = has1 ? addr_q[head] : 16'h0000;
        out_imm   = (is_len2 && has2) ? word_q[head_plus1] : 16'h0000;

        // Counting the in-flight read against capacity is what keeps a full FIFO lossless.
        mem_req  = !reset && !redirect && !stall_fetch && (occ_plus_pending < CW'(DEPTH));
        mem_addr = fetch_pc;

        // A redirect in the cycle the stale response arrives drops it (the kill case).
        push    = pending && !redirect;
        pop     = out_valid && out_ready;
        pop_cnt = pop ? (out_len2 ? CW'(2) : CW'(1)) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            pend_addr <= RESET_PC;
            pending   <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            pending <= mem_req;
            if (mem_req) begin
                pend_addr <= fetch_pc;
                fetch_pc  <= fetch_pc + 16'd1;
            end
            if (redirect) begin
                fetch_pc <= redirect_pc;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    tail <= tail + AW'(1);
                end
                head  <= head + AW'(pop_cnt);
                count <= count + CW'(push) - pop_cnt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            word_q[tail] <= mem_rdata;
            addr_q[tail] <= pend_addr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed sequences, an opcode vector table and a randomized run
// checked against an instruction-stream reference walk over the bench's memory image.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall_fetch;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ir;
    logic [15:0] out_imm;
    logic [15:0] out_pc;
    logic        out_len2;

    logic        b_mem_req;
    logic [15:0] b_mem_addr;
    logic [15:0] b_mem_rdata;
    logic        b_out_valid;
    logic [15:0] b_out_ir;
    logic [15:0] b_out_imm;
    logic [15:0] b_out_pc;
    logic        b_out_len2;

    logic [15:0] tb_mem [0:65535];
    logic [15:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int req_seen = 0;
    int hs_cnt = 0;
    logic [15:0] exp_pc = 16'h0000;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] w0;
        logic [15:0] w1;
        logic        exp_len2;
        logic [15:0] exp_imm;
        logic [15:0] exp_next;
        int          exp_lat;
    } vec_t;
    vec_t tbl [7];

    fetch_queue #(.DEPTH(4), .RESET_PC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall_fetch(stall_fetch), .out_valid(out_valid), .out_ready(out_ready),
        .out_ir(out_ir), .out_imm(out_imm), .out_pc(out_pc), .out_len2(out_len2)
    );

    fetch_queue #(.DEPTH(4), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .reset(reset), .mem_req(b_mem_req), .mem_addr(b_mem_addr),
        .mem_rdata(b_mem_rdata), .redirect(1'b0), .redirect_pc(16'h0000),
        .stall_fetch(1'b0), .out_valid(b_out_valid), .out_ready(1'b0),
        .out_ir(b_out_ir), .out_imm(b_out_imm), .out_pc(b_out_pc), .out_len2(b_out_len2)
    );

    // clock and memory responders (1-cycle read latency)
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_req) mem_rdata <= tb_mem[mem_addr];
        if (b_mem_req) b_mem_rdata <= tb_mem[b_mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: walk the instruction stream in memory; a redirect restarts the walk
    // after any handshake in the same cycle, reset restarts it at the reset PC.
    task automatic monitor();
        logic [15:0] ir;
        logic        len2;
        logic [15:0] imm;
        if (reset) begin
            exp_pc = 16'h0000;
        end else begin
            if (stall_fetch || redirect) chk("no_req_when_blocked", 32'(mem_req), 32'd0);
            if (out_valid && out_ready) begin
                ir   = tb_mem[exp_pc];
                len2 = (ir[15:12] == 4'hC) || (ir[15:12] == 4'hD) || (ir[15:12] == 4'hE);
                imm  = len2 ? tb_mem[exp_pc + 16'd1] : 16'h0000;
                chk("sb_pc", 32'(out_pc), 32'(exp_pc));
                chk("sb_ir", 32'(out_ir), 32'(ir));
                chk("sb_len2", 32'(out_len2), 32'(len2));
                chk("sb_imm", 32'(out_imm), 32'(imm));
                exp_pc = exp_pc + (len2 ? 16'd2 : 16'd1);
                hs_cnt++;
            end
            if (redirect) exp_pc = redirect_pc;
            if (mem_req) req_seen++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int snap;
        int lat;
        tbl[0] = '{16'h0200, 16'hC123, 16'h0456, 1'b1, 16'h0456, 16'h0202, 4};
        tbl[1] = '{16'h0210, 16'hD000, 16'h0040, 1'b1, 16'h0040, 16'h0212, 4};
        tbl[2] = '{16'h0220, 16'hE7FF, 16'h1234, 1'b1, 16'h1234, 16'h0222, 4};
        tbl[3] = '{16'h0230, 16'hB000, 16'h5555, 1'b0, 16'h0000, 16'h0231, 3};
        tbl[4] = '{16'h0240, 16'hF000, 16'h7777, 1'b0, 16'h0000, 16'h0241, 3};
        tbl[5] = '{16'h0250, 16'h0000, 16'h2222, 1'b0, 16'h0000, 16'h0251, 3};
        tbl[6] = '{16'h0260, 16'h1123, 16'hC000, 1'b0, 16'h0000, 16'h0261, 3};

        for (int i = 0; i < 65536; i++) tb_mem[i] = 16'h1000 | (16'(i) & 16'h0FFF);
        tb_mem[0]       = 16'h1123;
        tb_mem[4]       = 16'hD000;
        tb_mem[5]       = 16'h0040;
        tb_mem[16'hFFFF] = 16'hC0DE;
        tb_mem[16'h0100] = 16'h1ABC;

        reset = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000;
        stall_fetch = 1'b0; out_ready = 1'b1;
        tick();
        tick();

        // reset state and first fetches (cycle R)
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_ir", 32'(out_ir), 32'd0);
        chk("rst_out_imm", 32'(out_imm), 32'd0);
        chk("rst_out_pc", 32'(out_pc), 32'd0);
        chk("rst_out_len2", 32'(out_len2), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
        chk("wrap_addr_r", 32'(b_mem_addr), 32'hFFFF);
        tick(); // R+1
        chk("a_mem_addr1", 32'(mem_addr), 32'h0001);
        chk("wrap_addr_r1", 32'(b_mem_addr), 32'h0000);
        tick(); // R+2
        chk("a_valid0", 32'(out_valid), 32'd1);
        chk("a_ir0", 32'(out_ir), 32'h1123);
        chk("a_pc0", 32'(out_pc), 32'd0);
        chk("a_len2_0", 32'(out_len2), 32'd0);
        chk("wrap_addr_r2", 32'(b_mem_addr), 32'h0001);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk("a_valid_k", 32'(out_valid), 32'd1);
            chk("a_pc_k", 32'(out_pc), 32'(k));
            if (k == 1) begin
                chk("wrap_valid", 32'(b_out_valid), 32'd1);
                chk("wrap_ir", 32'(b_out_ir), 32'hC0DE);
                chk("wrap_imm", 32'(b_out_imm), 32'h1123);
                chk("wrap_pc", 32'(b_out_pc), 32'hFFFF);
                chk("wrap_len2", 32'(b_out_len2), 32'd1);
            end
        end
        tick(); // R+6: only the first word of D000 is present
        chk("a_bubble", 32'(out_valid), 32'd0);
        tick(); // R+7
        chk("a_jmp_valid", 32'(out_valid), 32'd1);
        chk("a_jmp_ir", 32'(out_ir), 32'hD000);
        chk("a_jmp_imm", 32'(out_imm), 32'h0040);
        chk("a_jmp_pc", 32'(out_pc), 32'h0004);
        chk("a_jmp_len2", 32'(out_len2), 32'd1);
        tick(); // R+8
        chk("a_after_jmp_pc", 32'(out_pc), 32'h0006);

        // saturation: hold the core off for 20 cycles
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0000;
        #1;
        chk("b_redirect_no_req", 32'(mem_req), 32'd0);
        snap = req_seen;
        tick();
        redirect = 1'b0;
        for (int k = 0; k < 20; k++) tick();
        chk("b_req_count", 32'(req_seen - snap), 32'd4);
        chk("b_full_no_req", 32'(mem_req), 32'd0);
        chk("b_held_addr", 32'(mem_addr), 32'h0004);
        chk("b_full_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 4; k++) exp_q.push_back(16'(k));
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("b_drain_valid", 32'(out_valid), 32'd1);
            chk("b_drain_pc", 32'(out_pc), 32'(exp_q.pop_front()));
            tick();
        end

        // back-to-back redirects while reads are in flight
        tick(); tick(); tick();
        redirect = 1'b1; redirect_pc = 16'h0300;
        tick();
        redirect_pc = 16'h0100;
        #1;
        chk("c_redirect_no_req", 32'(mem_req), 32'd0);
        tick(); // T+1
        redirect = 1'b0;
        #1;
        chk("c_t1_req", 32'(mem_req), 32'd1);
        chk("c_t1_addr", 32'(mem_addr), 32'h0100);
        chk("c_t1_valid", 32'(out_valid), 32'd0);
        tick(); // T+2
        chk("c_t2_valid", 32'(out_valid), 32'd0);
        tick(); // T+3
        chk("c_t3_valid", 32'(out_valid), 32'd1);
        chk("c_t3_pc", 32'(out_pc), 32'h0100);
        chk("c_t3_ir", 32'(out_ir), 32'h1ABC);

        // opcode table: redirect onto each vector, check latency, fields and next PC
        for (int i = 0; i < 7; i++) begin
            out_ready = 1'b0;
            tb_mem[tbl[i].pc] = tbl[i].w0;
            tb_mem[tbl[i].pc + 16'd1] = tbl[i].w1;
            redirect = 1'b1; redirect_pc = tbl[i].pc;
            tick();
            redirect = 1'b0;
            lat = 1;
            #1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk("t_latency", 32'(lat), 32'(tbl[i].exp_lat));
            chk("t_valid", 32'(out_valid), 32'd1);
            chk("t_pc", 32'(out_pc), 32'(tbl[i].pc));
            chk("t_ir", 32'(out_ir), 32'(tbl[i].w0));
            chk("t_len2", 32'(out_len2), 32'(tbl[i].exp_len2));
            chk("t_imm", 32'(out_imm), 32'(tbl[i].exp_imm));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            lat = 0;
            #1;
            while (!out_valid && lat < 10) begin
                tick();
                lat++;
            end
            chk("t_next_valid", 32'(out_valid), 32'd1);
            chk("t_next_pc", 32'(out_pc), 32'(tbl[i].exp_next));
        end

        // stall with three words queued, then reset mid-burst
        for (int i = 16'h0800; i < 16'h1000; i++) tb_mem[i] = 16'($urandom);
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0400;
        tick(); // T+1
        redirect = 1'b0;
        tick(); tick(); tick(); // T+4
        stall_fetch = 1'b1;
        #1;
        chk("f_stall_no_req", 32'(mem_req), 32'd0);
        tick(); // T+5
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("f_drain_valid", 32'(out_valid), 32'd1);
            chk("f_drain_pc", 32'(out_pc), 32'(16'h0400 + k));
            tick();
        end
        chk("f_empty_valid", 32'(out_valid), 32'd0);
        chk("f_empty_req", 32'(mem_req), 32'd0);
        tick();
        stall_fetch = 1'b0;
        #1;
        chk("f_resume_req", 32'(mem_req), 32'd1);
        chk("f_resume_addr", 32'(mem_addr), 32'h0403);
        for (int k = 0; k < 4; k++) tick();
        reset = 1'b1;
        #1;
        chk("f_reset_no_req", 32'(mem_req), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("f_rst_valid", 32'(out_valid), 32'd0);
        chk("f_rst_ir", 32'(out_ir), 32'd0);
        chk("f_rst_imm", 32'(out_imm), 32'd0);
        chk("f_rst_pc", 32'(out_pc), 32'd0);
        chk("f_rst_len2", 32'(out_len2), 32'd0);
        chk("f_rst_addr", 32'(mem_addr), 32'h0000);
        chk("f_rst_wrap_valid", 32'(b_out_valid), 32'd0);

        // randomized traffic against the stream reference
        snap = hs_cnt;
        for (int k = 0; k < 3000; k++) begin
            tick();
            out_ready   = ($urandom_range(0, 3) != 0);
            stall_fetch = ($urandom_range(0, 15) == 0);
            redirect    = ($urandom_range(0, 29) == 0);
            redirect_pc = 16'h0800 + 16'($urandom_range(0, 2000));
        end
        redirect = 1'b0;
        stall_fetch = 1'b0;
        tick();
        chk("g_progress", 32'(hs_cnt - snap > 500), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
